// File: rtl/pp_accumulator_if.sv
// rtl/pp_accumulator_if.sv - handshake bundle between Booth PP generator, accumulator and consumer
interface pp_accumulator_if #(
  parameter int PP_W  = 33,
  parameter int OUT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [PP_W-1:0]  pp_in0,  pp_in1,  pp_in2,  pp_in3;
  logic [PP_W-1:0]  pp_in4,  pp_in5,  pp_in6,  pp_in7;
  logic [PP_W-1:0]  pp_in8,  pp_in9,  pp_in10, pp_in11;
  logic [PP_W-1:0]  pp_in12, pp_in13, pp_in14, pp_in15;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;
  logic             busy;

  modport master (
    output in_valid, out_ready,
    output pp_in0, pp_in1, pp_in2, pp_in3, pp_in4, pp_in5, pp_in6, pp_in7,
    output pp_in8, pp_in9, pp_in10, pp_in11, pp_in12, pp_in13, pp_in14, pp_in15,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, out_ready,
    input  pp_in0, pp_in1, pp_in2, pp_in3, pp_in4, pp_in5, pp_in6, pp_in7,
    input  pp_in8, pp_in9, pp_in10, pp_in11, pp_in12, pp_in13, pp_in14, pp_in15,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/pp_accumulator.sv
// rtl/pp_accumulator.sv - sequential reduction of 16 Booth partial products into a 64-bit product
// PP_ACC_DUAL_EN defined: two groups per cycle (8 steps); undefined: one group per cycle (16 steps).
module pp_accumulator #(
  parameter int NUM_PP = 16,
  parameter int PP_W   = 33,
  parameter int OUT_W  = 64
) (
  input logic             clk,
  input logic             reset,
  pp_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_PP);
`ifdef PP_ACC_DUAL_EN
  localparam int STEPS = NUM_PP / 2;
`else
  localparam int STEPS = NUM_PP;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [PP_W-1:0]  pp_in [NUM_PP];
  logic [PP_W-1:0]  pp_q  [NUM_PP];
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic [OUT_W-1:0] product_q;
  logic             out_valid_q;
  logic             accept;
  logic             last;

  assign pp_in[0]  = bus.pp_in0;
  assign pp_in[1]  = bus.pp_in1;
  assign pp_in[2]  = bus.pp_in2;
  assign pp_in[3]  = bus.pp_in3;
  assign pp_in[4]  = bus.pp_in4;
  assign pp_in[5]  = bus.pp_in5;
  assign pp_in[6]  = bus.pp_in6;
  assign pp_in[7]  = bus.pp_in7;
  assign pp_in[8]  = bus.pp_in8;
  assign pp_in[9]  = bus.pp_in9;
  assign pp_in[10] = bus.pp_in10;
  assign pp_in[11] = bus.pp_in11;
  assign pp_in[12] = bus.pp_in12;
  assign pp_in[13] = bus.pp_in13;
  assign pp_in[14] = bus.pp_in14;
  assign pp_in[15] = bus.pp_in15;

  // A retiring result and a new accept can share the same DONE cycle.
  assign bus.in_ready  = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign last          = (count == CNT_W'(STEPS - 1));
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = (state == S_ACC);

  function automatic logic [OUT_W-1:0] weigh(input logic [PP_W-1:0] pp, input logic [5:0] sh);
    return {{(OUT_W - PP_W){pp[PP_W-1]}}, pp} << sh;
  endfunction

`ifdef PP_ACC_DUAL_EN
  always_comb begin
    acc_next = acc
             + weigh(pp_q[{count[CNT_W-2:0], 1'b0}], {1'b0, count[CNT_W-2:0], 2'b00})
             + weigh(pp_q[{count[CNT_W-2:0], 1'b1}], {1'b0, count[CNT_W-2:0], 2'b10});
  end
`else
  always_comb begin
    acc_next = acc + weigh(pp_q[count], {1'b0, count, 1'b0});
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      acc         <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      pp_q        <= '{default: '0};
    end else if (accept) begin
      pp_q        <= pp_in;
      acc         <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      state       <= S_ACC;
    end else begin
      case (state)
        S_ACC: begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (last) begin
            product_q   <= acc_next;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pp_accumulator.sv
// tb/tb_pp_accumulator.sv - directed and random Booth-product checks for pp_accumulator
module tb_pp_accumulator;
`ifdef PP_ACC_DUAL_EN
  localparam int STEPS = 8;
`else
  localparam int STEPS = 16;
`endif
  localparam longint MAXP = 64'sd4294967295;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [32:0] pp_set [16];
  int          errors = 0;
  int          checks = 0;

  pp_accumulator_if bus ();

  pp_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.pp_in0  = pp_set[0];
  assign bus.pp_in1  = pp_set[1];
  assign bus.pp_in2  = pp_set[2];
  assign bus.pp_in3  = pp_set[3];
  assign bus.pp_in4  = pp_set[4];
  assign bus.pp_in5  = pp_set[5];
  assign bus.pp_in6  = pp_set[6];
  assign bus.pp_in7  = pp_set[7];
  assign bus.pp_in8  = pp_set[8];
  assign bus.pp_in9  = pp_set[9];
  assign bus.pp_in10 = pp_set[10];
  assign bus.pp_in11 = pp_set[11];
  assign bus.pp_in12 = pp_set[12];
  assign bus.pp_in13 = pp_set[13];
  assign bus.pp_in14 = pp_set[14];
  assign bus.pp_in15 = pp_set[15];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: weighted sum of the captured set, each term times 4^i.
  function automatic logic [63:0] ref_sum();
    longint s = 0;
    for (int i = 0; i < 16; i++)
      s += longint'($signed(pp_set[i])) * (longint'(1) << (2 * i));
    return s;
  endfunction

  // Radix-4 Booth generator; a +2^32 term does not fit 33 bits, so it is
  // clamped and the excess pushed down one group (x4 weight).
  task automatic gen_booth(input logic [31:0] a, input logic [31:0] b);
    longint      v [16];
    logic [32:0] bx;
    int          d;
    bx = {b, 1'b0};
    for (int i = 0; i < 16; i++) begin
      d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      v[i] = longint'(d) * longint'($signed(a));
    end
    for (int i = 15; i > 0; i--)
      if (v[i] > MAXP) begin
        v[i-1] += 4 * (v[i] - MAXP);
        v[i] = MAXP;
      end
    for (int i = 0; i < 16; i++) pp_set[i] = v[i][32:0];
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] exp, input int hold);
    int n;
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) pp_set[i] = {$urandom, $urandom} & 33'h1_FFFF_FFFF;
    wait_out(n);
    check({tag, "_latency"}, n, STEPS);
    repeat (hold) begin @(posedge clk); #1; end
    check({tag, "_product"}, bus.product, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_retired"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    int          n;
    logic        stale;
    logic [31:0] a, b;
    logic [63:0] exp_a, exp_b;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) pp_set[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_product", bus.product, 64'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    pp_set[0] = 33'd5;
    run_op("pp0_five", 64'd5, 0);

    for (int i = 0; i < 16; i++) pp_set[i] = '0;
    pp_set[15] = 33'h1_FFFF_FFFF;
    run_op("pp15_neg1", 64'hFFFF_FFFF_C000_0000, 0);

    gen_booth(32'h8000_0000, 32'h8000_0000);
    run_op("booth_min_min", 64'h4000_0000_0000_0000, 0);
    gen_booth(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("booth_m1_m1", 64'd1, 0);

    // Long hold in DONE, then retire and accept in the same cycle.
    for (int i = 0; i < 16; i++) pp_set[i] = '0;
    pp_set[3] = 33'h1_2345_6789;
    pp_set[9] = 33'h0_0000_0ABC;
    exp_a = ref_sum();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("hold_busy", bus.busy, 1'b1);
    wait_out(n);
    check("hold_latency", n, STEPS);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_product", bus.product, exp_a);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    for (int i = 0; i < 16; i++) pp_set[i] = {$urandom, $urandom} & 33'h1_FFFF_FFFF;
    exp_b = ref_sum();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("overlap_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("overlap_out_valid", bus.out_valid, 1'b0);
    check("overlap_busy", bus.busy, 1'b1);
    wait_out(n);
    check("overlap_latency", n, STEPS);
    check("overlap_product", bus.product, exp_b);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of accumulation.
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_product", bus.product, 64'd0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_busy_low", bus.busy, 1'b0);
    stale = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    check("midrst_no_stale", stale, 1'b0);

    for (int t = 0; t < 200; t++) begin
      a = $urandom;
      b = $urandom;
      if (a == 32'h8000_0000) a = 32'h8000_0001;
      gen_booth(a, b);
      exp_a = longint'($signed(a)) * longint'($signed(b));
      run_op("rand", exp_a, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
